updown_seq_ctrl: RTL and testbench

- Sequencing controller for the 4-bit up/down counter datapath.
- Generates single-cycle step strobes at a selectable slow or fast rate and owns count direction, with bounce and wrap modes.
- Handles run/pause from a pushbutton level and a synchronous clear; the datapath counter itself stays a plain enable/direction/clear register.
- Sits between the board inputs and the counter; all outputs are clk-domain strobes, with no derived clocks.

---
 rtl/updown_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_updown_seq_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_seq_ctrl.sv
// Sequencing controller for the up/down counter datapath: run/pause, step prescaler,
// bounce/wrap direction control and synchronous clear, all as registered clk-domain strobes.
module updown_seq_ctrl #(
  parameter int WIDTH    = 4,
  parameter int SLOW_DIV = 25000000,
  parameter int FAST_DIV = 5000000,
  parameter int DIV_W    = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_btn,
  input  logic             a,
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             cnt_clr,
  output logic             turn,
  output logic             running,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_UP    = 2'b01,
    S_DOWN  = 2'b10,
    S_PAUSE = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] MAX    = '1;
  localparam logic [WIDTH-1:0] MAX_M1 = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO   = '0;
  localparam logic [DIV_W-1:0] SLOW_M1 = DIV_W'(SLOW_DIV - 1);
  localparam logic [DIV_W-1:0] FAST_M1 = DIV_W'(FAST_DIV - 1);
  localparam logic [DIV_W-1:0] P_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [DIV_W-1:0] r_presc;
  logic             r_dir;
  logic             r_btn_prev;
  logic             r_cnt_en, r_cnt_up, r_cnt_clr, r_turn, r_running;

  logic             w_press, w_tick, w_bounce, w_run;
  logic [DIV_W-1:0] w_div_m1;

  assign w_press  = run_btn & ~r_btn_prev;
  assign w_div_m1 = a ? FAST_M1 : SLOW_M1;
  // >= rather than == so a switch to a shorter period mid-count still ticks promptly
  assign w_tick   = (r_presc >= w_div_m1);
  assign w_bounce = (mode == 2'b00);
  assign w_run    = (r_state == S_UP) || (r_state == S_DOWN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_presc    <= '0;
      r_dir      <= 1'b1;
      r_btn_prev <= 1'b1;
      r_cnt_en   <= 1'b0;
      r_cnt_up   <= 1'b0;
      r_cnt_clr  <= 1'b0;
      r_turn     <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_btn_prev <= run_btn;
      r_cnt_en   <= 1'b0;
      r_cnt_clr  <= 1'b0;
      r_turn     <= 1'b0;
      if (clr) begin
        r_cnt_clr <= 1'b1;
        r_state   <= S_IDLE;
        r_presc   <= '0;
        r_running <= 1'b0;
      end else if (w_press) begin
        case (r_state)
          S_IDLE: begin
            r_state   <= (mode == 2'b10) ? S_DOWN : S_UP;
            r_presc   <= '0;
            r_running <= 1'b1;
          end
          S_UP, S_DOWN: begin
            r_dir     <= (r_state == S_UP);
            r_state   <= S_PAUSE;
            r_running <= 1'b0;
          end
          default: begin
            r_state   <= r_dir ? S_UP : S_DOWN;
            r_running <= 1'b1;
          end
        endcase
      end else if (w_run && mode != 2'b11) begin
        if (mode == 2'b01 && r_state == S_DOWN) begin
          r_state <= S_UP;
        end else if (mode == 2'b10 && r_state == S_UP) begin
          r_state <= S_DOWN;
        end else if (!w_tick) begin
          r_presc <= r_presc + P_ONE;
        end else begin
          r_presc  <= '0;
          r_cnt_en <= 1'b1;
          // at an endpoint in bounce the step itself reverses, so the endpoint is never repeated
          if (r_state == S_UP) begin
            r_cnt_up <= !(w_bounce && cnt_val == MAX);
            if (w_bounce && (cnt_val == MAX_M1 || cnt_val == MAX)) begin
              r_state <= S_DOWN;
              r_turn  <= 1'b1;
            end
          end else begin
            r_cnt_up <= (w_bounce && cnt_val == ZERO);
            if (w_bounce && (cnt_val == ONE || cnt_val == ZERO)) begin
              r_state <= S_UP;
              r_turn  <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign cnt_en  = r_cnt_en;
  assign cnt_up  = r_cnt_up;
  assign cnt_clr = r_cnt_clr;
  assign turn    = r_turn;
  assign running = r_running;
  assign state   = r_state;

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Directed + randomized bench for updown_seq_ctrl with a bench-side counter datapath
// and a triangle-wave reference for the bounce sequence.
module tb_updown_seq_ctrl;

  logic       clk, rst, run_btn, a, clr;
  logic [1:0] mode;
  logic [3:0] cnt;
  logic       cnt_en, cnt_up, cnt_clr, turn, running;
  logic [1:0] state;

  int cyc = 0;
  int en_total = 0;
  int n_chk = 0;
  int n_err = 0;

  updown_seq_ctrl #(.WIDTH(4), .SLOW_DIV(4), .FAST_DIV(2), .DIV_W(3)) dut (
    .clk(clk), .rst(rst), .run_btn(run_btn), .a(a), .mode(mode), .clr(clr),
    .cnt_val(cnt), .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_clr(cnt_clr),
    .turn(turn), .running(running), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cnt_en) en_total <= en_total + 1;

  // plain enable/direction/clear datapath register
  always @(posedge clk or negedge rst) begin
    if (!rst)         cnt <= 4'd0;
    else if (cnt_clr) cnt <= 4'd0;
    else if (cnt_en)  cnt <= cnt_up ? cnt + 4'd1 : cnt - 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    run_btn = 1'b1;
    step();
    run_btn = 1'b0;
  endtask

  // waits for the next cnt_en pulse (bounded), then one more edge so the datapath absorbs it
  task automatic do_step(output int t, output logic tn);
    t  = -1;
    tn = 1'b0;
    for (int k = 0; k < 64; k++) begin
      step();
      if (cnt_en) begin
        t  = cyc;
        tn = turn;
        break;
      end
    end
    chk("step_seen", (t >= 0), 1);
    step();
  endtask

  // position n of the 0..15..0 bounce sequence
  function automatic int tri_val(input int n);
    int m;
    m = n % 30;
    return (m <= 15) ? m : 30 - m;
  endfunction

  initial begin
    int t, p, r, c0, e0, nw, nrnd;
    logic tn;
    int wrap_up[3];
    wrap_up = '{15, 0, 1};

    rst = 1'b0; run_btn = 1'b1; a = 1'b0; mode = 2'b00; clr = 1'b0;
    e0 = en_total;
    repeat (10) step();
    chk("rst_state", state, 0);
    chk("rst_outs", {cnt_en, cnt_up, cnt_clr, turn, running}, 0);
    chk("rst_no_en", en_total, e0);

    rst = 1'b1;
    repeat (3) step();
    chk("held_btn_no_edge", state, 0);
    run_btn = 1'b0;
    step();
    press();
    chk("press_idle_up", state, 1);
    chk("running_up", running, 1);
    p = cyc;

    for (int n = 1; n <= 74; n++) begin
      do_step(t, tn);
      if (n == 1) chk("first_step_lat", t - p, 4);
      else        chk("bounce_period", t - p, 4);
      p = t;
      chk("bounce_val", cnt, tri_val(n));
      chk("bounce_turn", tn, (tri_val(n) == 0 || tri_val(n) == 15));
    end
    chk("up_at_14", state, 1);

    mode = 2'b01;
    for (int k = 0; k < 3; k++) begin
      do_step(t, tn);
      chk("upwrap_val", cnt, wrap_up[k]);
      chk("upwrap_no_turn", tn, 0);
    end

    mode = 2'b10;
    step();
    chk("force_down", state, 2);
    for (int k = 0; k < 10; k++) begin
      do_step(t, tn);
      chk("dnwrap_val", cnt, (1 - (k + 1)) & 15);
      chk("dnwrap_no_turn", tn, 0);
    end

    mode = 2'b00;
    press();
    chk("pause_state", state, 3);
    chk("pause_running", running, 0);
    e0 = en_total;
    nw = $urandom_range(30, 20);
    repeat (nw) step();
    chk("pause_no_en", en_total, e0);
    chk("pause_hold_cnt", cnt, 7);
    press();
    chk("resume_down", state, 2);
    r = cyc;
    do_step(t, tn);
    chk("resume_phase", t - r, 3);
    chk("resume_val", cnt, 6);

    step();
    a = 1'b1;
    c0 = cyc;
    do_step(t, tn);
    chk("speed_tick_next", t - c0, 1);
    chk("speed_val", cnt, 5);
    p = t;
    do_step(t, tn);
    chk("fast_period", t - p, 2);
    chk("fast_val", cnt, 4);

    clr = 1'b1; run_btn = 1'b1;
    step();
    chk("clr_strobe", cnt_clr, 1);
    chk("clr_no_en", cnt_en, 0);
    chk("clr_state", state, 0);
    chk("clr_running", running, 0);
    clr = 1'b0; run_btn = 1'b0;
    step();
    chk("clr_count", cnt, 0);
    chk("clr_one_cycle", cnt_clr, 0);

    a = 1'b0;
    press();
    chk("restart_up", state, 1);
    p = cyc;
    for (int k = 1; k <= 3; k++) begin
      do_step(t, tn);
      if (k == 1) chk("restart_lat", t - p, 4);
      chk("restart_val", cnt, k);
    end
    mode = 2'b11;
    e0 = en_total;
    nw = $urandom_range(16, 10);
    repeat (nw) step();
    chk("hold_no_en", en_total, e0);
    chk("hold_state", state, 1);
    chk("hold_cnt", cnt, 3);
    mode = 2'b00;
    c0 = cyc;
    do_step(t, tn);
    chk("hold_resume_phase", t - c0, 3);
    chk("hold_resume_val", cnt, 4);
    chk("hold_resume_dir", state, 1);

    // random speed per step over a random-length bounce run
    nrnd = $urandom_range(40, 20);
    for (int n = 1; n <= nrnd; n++) begin
      a = 1'($urandom_range(1, 0));
      do_step(t, tn);
      chk("rnd_bounce_val", cnt, tri_val(4 + n));
      chk("rnd_bounce_turn", tn, (tri_val(4 + n) == 0 || tri_val(4 + n) == 15));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
